// File: rtl/x_mult_ctrl.sv
//==============================================================================
// Module      : x_mult_ctrl
// Description : Sequential radix-2 Booth signed multiplier with start/abort,
//               advance enable and a one-cycle completion strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module x_mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ena,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] C_LAST_CNT = 6'(WIDTH);

    state_t           r_state, w_state_n;
    logic [5:0]       r_cnt, w_cnt_n;
    logic [WIDTH-1:0] r_a, w_a_n;
    logic [WIDTH:0]   r_acc, w_acc_n;
    logic [WIDTH-1:0] r_q, w_q_n;
    logic             r_qm1, w_qm1_n;
    logic [WIDTH-1:0] r_result, w_result_n;
    logic             r_exc, w_exc_n;
    logic             r_rdy, w_rdy_n;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_sum;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_a      <= w_a_n;
            r_acc    <= w_acc_n;
            r_q      <= w_q_n;
            r_qm1    <= w_qm1_n;
            r_result <= w_result_n;
            r_exc    <= w_exc_n;
            r_rdy    <= w_rdy_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_a_n      = r_a;
        w_acc_n    = r_acc;
        w_q_n      = r_q;
        w_qm1_n    = r_qm1;
        w_result_n = r_result;
        w_exc_n    = r_exc;
        w_rdy_n    = r_rdy;

        // ACC carries one extra bit so that subtracting -2^(WIDTH-1) stays exact
        w_a_ext = {r_a[WIDTH-1], r_a};
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_a_ext;
            2'b10:   w_sum = r_acc - w_a_ext;
            default: w_sum = r_acc;
        endcase

        if (ena) begin
            w_rdy_n = 1'b0;
            if (ctrl_mult) begin
                w_a_n     = data_operandA;
                w_acc_n   = '0;
                w_q_n     = data_operandB;
                w_qm1_n   = 1'b0;
                w_cnt_n   = '0;
                w_state_n = ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        w_acc_n = {w_sum[WIDTH], w_sum[WIDTH:1]};
                        w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
                        w_qm1_n = r_q[0];
                        w_cnt_n = r_cnt + 6'd1;
                        if (w_cnt_n == C_LAST_CNT) begin
                            w_state_n  = ST_DONE;
                            w_rdy_n    = 1'b1;
                            w_result_n = w_q_n;
                            w_exc_n    = (w_acc_n[WIDTH-1:0] != {WIDTH{w_q_n[WIDTH-1]}});
                        end
                    end
                    ST_DONE: w_state_n = ST_IDLE;
                    default: w_state_n = ST_IDLE;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_x_mult_ctrl.sv
//==============================================================================
// Module      : tb_x_mult_ctrl
// Description : Directed self-checking bench for the Booth multiplier control.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_x_mult_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        ena;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    x_mult_ctrl #(.WIDTH(32)) dut (
        .clk            (clk),
        .clrn           (clrn),
        .ena            (ena),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start and count edges until the strobe, bounded at 100 edges
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            output int edges, output int busy_cyc);
        data_operandA = a;
        data_operandB = b;
        ctrl_mult     = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        edges     = 0;
        busy_cyc  = busy ? 1 : 0;
        while (!data_resultRDY && edges < 100) begin
            tick();
            edges++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; ena = 1'b1; ctrl_mult = 1'b0;
        data_operandA = '0; data_operandB = '0;
        tick(); tick();
        n_vec++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b, want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        clrn = 1'b1;
    endtask

    task automatic test_basic();
        int edges, bcyc;
        run_mult(32'd3, 32'd5, edges, bcyc);
        n_vec++;
        if (edges !== 32) begin
            n_err++; $display("FAIL basic_latency: got %0d edges, want 32", edges);
        end
        n_vec++;
        if (bcyc !== 32) begin
            n_err++; $display("FAIL basic_busy: got %0d busy cycles, want 32", bcyc);
        end
        n_vec++;
        if (data_result !== 32'h0000000F || data_exception !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: got %h/%b, want 0000000f/0", data_result, data_exception);
        end
        tick();
        n_vec++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'h0000000F) begin
            n_err++;
            $display("FAIL basic_strobe_width: got rdy=%b busy=%b res=%h, want 0/0/0000000f",
                     data_resultRDY, busy, data_result);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [7] = '{32'hFFFFFFF9, 32'h00010000, 32'h80000000, 32'h80000000,
                                32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] vb [7] = '{32'h00000006, 32'h00010000, 32'hFFFFFFFF, 32'h00000001,
                                32'h00000002, 32'hFFFFFFFF, 32'h12345678};
        logic [31:0] vr [7] = '{32'hFFFFFFD6, 32'h00000000, 32'h80000000, 32'h80000000,
                                32'hFFFFFFFE, 32'h00000001, 32'h00000000};
        logic        ve [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int edges, bcyc;
        for (int i = 0; i < 7; i++) begin
            run_mult(va[i], vb[i], edges, bcyc);
            n_vec++;
            if (edges !== 32 || data_result !== vr[i] || data_exception !== ve[i]) begin
                n_err++;
                $display("FAIL vector_%0d: %h*%h got edges=%0d res=%h exc=%b, want 32 %h %b",
                         i, va[i], vb[i], edges, data_result, data_exception, vr[i], ve[i]);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        int early = 0;
        int edges, bcyc;
        data_operandA = 32'd100; data_operandB = 32'd100; ctrl_mult = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (data_resultRDY) early++;
        end
        run_mult(32'd2, 32'd2, edges, bcyc);
        n_vec++;
        if (early !== 0 || edges !== 32) begin
            n_err++;
            $display("FAIL abort_latency: got early_rdy=%0d edges=%0d, want 0 and 32", early, edges);
        end
        n_vec++;
        if (data_result !== 32'h00000004 || data_exception !== 1'b0) begin
            n_err++;
            $display("FAIL abort_result: got %h/%b, want 00000004/0", data_result, data_exception);
        end
        tick();
    endtask

    task automatic test_ena_stall();
        int edges = 0;
        int stall_bad = 0;
        data_operandA = 32'd7; data_operandB = 32'd9; ctrl_mult = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        while (!data_resultRDY && edges < 100) begin
            ena = !(edges >= 10 && edges < 15);
            // A start while stalled must be dropped, not queued
            ctrl_mult = (edges == 12);
            data_operandA = (edges == 12) ? 32'd1000 : 32'd7;
            tick();
            edges++;
            if (!ena && !busy) stall_bad++;
        end
        ena = 1'b1; ctrl_mult = 1'b0;
        n_vec++;
        if (edges !== 37 || stall_bad !== 0) begin
            n_err++;
            $display("FAIL stall_latency: got %0d edges (busy drops %0d), want 37 (0)", edges, stall_bad);
        end
        n_vec++;
        if (data_result !== 32'd63 || data_exception !== 1'b0) begin
            n_err++;
            $display("FAIL stall_result: got %h/%b, want 0000003f/0", data_result, data_exception);
        end
        ena = 1'b0;
        tick(); tick();
        n_vec++;
        if (data_resultRDY !== 1'b1) begin
            n_err++; $display("FAIL stall_rdy_hold: got rdy=%b, want 1", data_resultRDY);
        end
        ena = 1'b1;
        tick();
        n_vec++;
        if (data_resultRDY !== 1'b0 || data_result !== 32'd63) begin
            n_err++;
            $display("FAIL stall_rdy_release: got rdy=%b res=%h, want 0/0000003f",
                     data_resultRDY, data_result);
        end
    endtask

    task automatic test_reset_mid_run();
        int late = 0;
        int edges, bcyc;
        data_operandA = 32'hFFFFFFFF; data_operandB = 32'd5; ctrl_mult = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #2 clrn = 1'b0;
        #1;
        n_vec++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            n_err++;
            $display("FAIL async_reset: got res=%h exc=%b rdy=%b busy=%b, want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        tick();
        clrn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_resultRDY || busy) late++;
        end
        n_vec++;
        if (late !== 0) begin
            n_err++; $display("FAIL reset_no_strobe: got %0d active cycles, want 0", late);
        end
        run_mult(32'd6, 32'd7, edges, bcyc);
        n_vec++;
        if (edges !== 32 || data_result !== 32'd42 || data_exception !== 1'b0) begin
            n_err++;
            $display("FAIL reset_restart: got edges=%0d res=%h exc=%b, want 32 0000002a 0",
                     edges, data_result, data_exception);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_abort();
        test_ena_stall();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/x_mult_ctrl.md
X_MULT_CTRL -- requirements
Module: x_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; all values below assume 32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  advance enable; low freezes all state and ignores ctrl_mult.
REQ-005 ctrl_mult  input  1  start pulse; operands sampled on the same edge.
REQ-006 data_operandA  input  WIDTH  multiplicand, two's complement.
REQ-007 data_operandB  input  WIDTH  multiplier, two's complement.
REQ-008 data_result  output  WIDTH  low WIDTH bits of the signed product.
REQ-009 data_exception  output  1  product not representable in signed WIDTH bits.
REQ-010 data_resultRDY  output  1  one-cycle completion strobe.
REQ-011 busy  output  1  high while state is RUN.

Function
REQ-012 FSM states: IDLE, RUN, DONE; fully registered; no combinational input-to-output path.
REQ-013 Algorithm: radix-2 Booth; product register {ACC[WIDTH:0], Q[WIDTH-1:0], q-1}; ACC is WIDTH+1 bits, sign-extended, so that A = -2^31 is exact.
REQ-014 Start edge (ena=1, ctrl_mult=1, any state): latch A; load ACC=0, Q=B, q-1=0; counter=0; state becomes RUN.
REQ-015 Each RUN edge with ena=1: Q[0],q-1 = 01 -> ACC+=A; 10 -> ACC-=A; 00/11 -> no add; then arithmetic right shift of the whole register by 1; counter+=1.
REQ-016 Counter is 6 bits; on the edge where the counter reaches 32, state becomes DONE and data_resultRDY becomes 1.
REQ-017 Latency: data_resultRDY is high in the cycle after the 32nd ena-qualified edge following the start edge, for exactly one cycle.
REQ-018 DONE -> IDLE on the next ena edge, unless ctrl_mult=1 (REQ-014 applies).
REQ-019 data_result = Q at completion; it is registered at the DONE transition and held until the next DONE transition or reset.
REQ-020 data_exception = 1 when the 64-bit product's upper 32 bits are not all equal to result bit 31; it is updated and held together with data_result.
REQ-021 ctrl_mult during RUN aborts the current operation and restarts with new operands; the aborted operation produces no strobe.
REQ-022 ena=0: state, counter, product, and outputs hold; a data_resultRDY already high stays high until the next ena edge.
REQ-023 ctrl_mult with ena=0 is ignored; it is not queued.
REQ-024 busy = 1 in RUN only; busy is 0 in DONE and IDLE.

Reset
REQ-025 clrn=0 immediately forces IDLE, counter=0, product=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0, regardless of clk.
REQ-026 Reset during RUN discards the operation; no strobe follows reset release.
REQ-027 The first start is accepted on the first rising edge with clrn=1, ena=1, and ctrl_mult=1.

Verification
REQ-028 3 x 5, ena=1 -> RDY exactly 32 edges after the start edge; result=0x0000000F; exception=0; busy high for 32 cycles.
REQ-029 -7 x 6 -> result=0xFFFFFFD6, exception=0; 0x00010000 x 0x00010000 -> result=0x00000000, exception=1.
REQ-030 0x80000000 x 0xFFFFFFFF -> result=0x80000000, exception=1; 0x80000000 x 0x00000001 -> result=0x80000000, exception=0.
REQ-031 Start 100 x 100, re-pulse ctrl_mult with 2 x 2 at RUN iteration 10 -> single RDY 32 edges after the second start; result=0x00000004.
REQ-032 ena low for 5 cycles mid-RUN -> RDY delayed by exactly 5 cycles; result unchanged.
REQ-033 clrn low at RUN iteration 20 -> all outputs 0 asynchronously; no RDY after release; next start completes normally.
